sum_window_avg: RTL
===================

# sum_window_avg

Downstream consumer of the `add_4_nums` adder stage. It takes the registered 10-bit four-operand sum whenever the adder's enable qualifies it. It accumulates `2**LOG2_N` consecutive qualified sums and emits their rounded mean through a one-entry valid/ready output register. A sticky overflow flag records any window result lost to back-pressure.

## Interface
Parameters:
- `W_IN`, 10, width of incoming sum; also width of `o_avg`
- `LOG2_N`, 2, log2 of window length N; legal range 1..4

Ports:
- `r_clk`  input  1  clock; all state updates on rising edge
- `r_rst_n`  input  1  reset, synchronous, active-low
- `i_valid`  input  1  `i_sum` qualified this cycle; driven from the adder's enable, delayed to align with its registered sum
- `i_sum`  input  `W_IN`  unsigned sum from the upstream adder
- `i_clear`  input  1  discard partial window; clear `o_ovf`
- `i_ready`  input  1  downstream accepts `o_avg` this cycle
- `o_valid`  output  1  `o_avg` holds an unconsumed result
- `o_avg`  output  `W_IN`  rounded window mean
- `o_cnt`  output  `LOG2_N`  samples collected in the current window, 0..N-1
- `o_ovf`  output  1  sticky: a window result was dropped

## Operation
- Internal state:
  - accumulator `acc` of width `W_IN+LOG2_N`; cannot overflow
  - sample counter `cnt`, driving `o_cnt`
  - output register: `o_valid`, `o_avg`
- Two-state FSM on the counter:
  - FILL: `cnt` < N-1.
  - LAST: `cnt` == N-1.
  - A qualified sample in FILL adds to `acc` and increments `cnt`.
  - A qualified sample in LAST completes the window:
    - result = (`acc` + `i_sum` + 2**(LOG2_N-1)) >> LOG2_N (round half up)
    - `acc` := 0, `cnt` := 0, FSM := FILL
- Result range: the result never exceeds 2**`W_IN`-1, so no saturation logic is needed. Truncate to `W_IN` bits.
- Output register:
  - An accepting handshake is `o_valid` && `i_ready` at a rising edge.
  - When a window completes and the register is empty, or is being accepted in the same cycle: load the result, `o_valid` := 1. No bubble.
  - When a window completes while `o_valid`=1 and `i_ready`=0: the new result is dropped, the old `o_avg` is held, `o_ovf` := 1.
  - Accepting handshake with no completion in the same cycle: `o_valid` := 0. `o_avg` holds its last value.
- `i_clear`:
  - sets `acc` := 0, `cnt` := 0, FSM := FILL, `o_ovf` := 0
  - leaves the output register and handshake unaffected
  - with `i_valid` in the same cycle, clear wins and the sample is discarded
- `i_valid`=0 cycles leave `acc` and `cnt` unchanged. Gaps inside a window are allowed.
- `i_sum` is ignored when `i_valid`=0.

## Timing
- Reset (`r_rst_n`=0 at a rising edge) forces:
  - `o_valid`=0, `o_avg`=0, `o_cnt`=0, `o_ovf`=0
  - internal `acc`=0, FSM=FILL
- Reset overrides `i_clear`, `i_valid` and handshakes in the same cycle.
- Reset mid-window discards the partial window and any pending output.
- Latency: the Nth qualified sample is sampled at edge k; `o_valid`=1 with `o_avg` is visible after edge k.
- Throughput: one sample per cycle sustained. With `i_ready` tied high, windows complete every N qualified samples with no stall.
- `o_valid` stays high and `o_avg` stays stable until accepted. No combinational path from `i_ready` to `o_valid`.
- `o_ovf` sets at the edge of the dropping completion and stays high until `i_clear` or reset.
- No input-side ready: the upstream adder cannot stall. Loss is reported only via `o_ovf`.

## Test plan
All scenarios use default parameters (N=4).
- Basic mean: reset, then `i_valid`=1 with `i_sum`=100,200,300,401 on consecutive cycles, `i_ready`=1 → one cycle after the 4th sample `o_valid`=1 and `o_avg`=250 (1001+2>>2). `o_cnt` reads 1,2,3,0. `o_ovf`=0.
- Rounding and extremes:
  - 1,1,1,2 → 1
  - 1,1,1,1 → 1
  - 0,0,0,2 → 1 (2+2>>2)
  - four samples of 1020 → 1020
  - four samples of 1023 → 1023; no wrap
- Gaps and back-pressure:
  - samples separated by random `i_valid`=0 gaps → same results as the gapless run
  - `i_ready`=0 across two window completions → first result held, second dropped, `o_ovf`=1
  - raise `i_ready` → first result accepted once
- Same-cycle load: `i_ready`=1 at the edge where the next window completes with `o_valid`=1 → `o_valid` stays 1 and `o_avg` updates to the new mean with no gap.
- Clear and reset:
  - `i_clear` after 2 samples, with `i_valid`=1 in the same cycle → `o_cnt`=0, that sample ignored; the next 4 samples form a full window
  - `i_clear` clears a set `o_ovf`
  - `r_rst_n`=0 with `o_valid`=1 and `cnt`=3 → all outputs 0 at the next edge
- Randomized: drive the enable pattern 5 cycles off / 10 on with random 8-bit operands summed by `add_4_nums` → every `o_avg` matches the scoreboard rounded mean of its 4 sums.

Source files
------------

// File: rtl/sum_window_avg.sv
// Averages 2**LOG2_N qualified sums; result is visible the cycle after the last sample.
// The one-entry output register holds until accepted; a completion while it is full is dropped and flags o_ovf.
module sum_window_avg #(
  parameter int W_IN   = 10,
  parameter int LOG2_N = 2
) (
  input  logic              r_clk,
  input  logic              r_rst_n,
  input  logic              i_valid,
  input  logic [W_IN-1:0]   i_sum,
  input  logic              i_clear,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [W_IN-1:0]   o_avg,
  output logic [LOG2_N-1:0] o_cnt,
  output logic              o_ovf
);

  localparam int AW = W_IN + LOG2_N;
  localparam int N  = 1 << LOG2_N;
  localparam logic [LOG2_N-1:0] CNT_PRE = LOG2_N'(N - 2);
  localparam logic [AW-1:0]     HALF    = AW'(N / 2);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] LAST = 1'b1;

  logic [AW-1:0]     acc;
  logic [LOG2_N-1:0] cnt;
  logic [0:0]        state;

  logic [AW-1:0]   sum_ext;
  logic [AW-1:0]   acc_next;
  logic [AW-1:0]   rounded;
  logic [W_IN-1:0] result;
  logic            sample;
  logic            complete;
  logic            load;
  logic            drop;
  logic            accept;

  // N*(2**W_IN-1) + N/2 still fits in AW bits, so the rounded sum never wraps.
  assign sum_ext  = {{LOG2_N{1'b0}}, i_sum};
  assign acc_next = acc + sum_ext;
  assign rounded  = acc_next + HALF;
  assign result   = rounded[AW-1:LOG2_N];

  assign sample   = i_valid && !i_clear;
  assign complete = sample && (state == LAST);
  assign accept   = o_valid && i_ready;
  assign load     = complete && (!o_valid || i_ready);
  assign drop     = complete && o_valid && !i_ready;

  always_ff @(posedge r_clk) begin
    if (!r_rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      state   <= FILL;
      o_valid <= 1'b0;
      o_avg   <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (i_clear) begin
        acc   <= '0;
        cnt   <= '0;
        state <= FILL;
        o_ovf <= 1'b0;
      end else if (i_valid) begin
        if (state == LAST) begin
          acc   <= '0;
          cnt   <= '0;
          state <= FILL;
        end else begin
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          state <= (cnt == CNT_PRE) ? LAST : FILL;
        end
      end

      if (drop) begin
        o_ovf <= 1'b1;
      end

      if (load) begin
        o_valid <= 1'b1;
        o_avg   <= result;
      end else if (accept) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign o_cnt = cnt;

endmodule
